// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage register file with pending-write scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_PEND_W   = 2;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file: read ports, write/retire, issue and hazard status.
interface regfile_scoreboard_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int NUM_RD = 2
);

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     retire;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_dest;
  logic                     issue_stall;
  logic                     any_pending;

  modport master (
    output we, waddr, wdata, retire, raddr, issue_valid, issue_dest,
    input  rdata, rbusy, issue_stall, any_pending
  );

  modport slave (
    input  we, waddr, wdata, retire, raddr, issue_valid, issue_dest,
    output rdata, rbusy, issue_stall, any_pending
  );

endinterface

// File: rtl/regfile_pend_counter.sv
// Saturating up/down counter tracking outstanding writes to one architectural register.
module regfile_pend_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              sat,
  output logic              zero
);

  logic [PEND_W-1:0] cnt_q, cnt_d;

  assign cnt  = cnt_q;
  assign sat  = &cnt_q;
  assign zero = (cnt_q == '0);

  // Simultaneous inc and dec cancel; the guards keep the count inside [0, max].
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (inc && !dec && !sat) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-through bypass, optional zero register and
// per-register pending-write counters so decode can stall on RAW hazards.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = DEF_PEND_W,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input logic                  clk,
  input logic                  reset,
  regfile_scoreboard_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec, dec_vec, sat_vec, zero_vec;

  logic wr_en;
  logic dest_is_zero;
  logic inc_ok;
  logic dec_ok;

  logic [DATA_W-1:0] rd_val  [NUM_RD];
  logic              rd_busy [NUM_RD];

  assign wr_en        = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign dest_is_zero = (ZERO_REG != 0) && (bus.issue_dest == '0);

  assign bus.issue_stall = bus.issue_valid && sat_vec[bus.issue_dest];
  assign inc_ok          = bus.issue_valid && !bus.issue_stall && !dest_is_zero;
  assign dec_ok          = bus.we && bus.retire && !zero_vec[bus.waddr];
  assign bus.any_pending = ~&zero_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    inc_vec[bus.issue_dest] = inc_ok;
    dec_vec[bus.waddr]      = dec_ok;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    regfile_pend_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (inc_vec[r]),
      .dec   (dec_vec[r]),
      .cnt   (pend[r]),
      .sat   (sat_vec[r]),
      .zero  (zero_vec[r])
    );
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.waddr] = bus.wdata;
    end
  end

  // NOTE: the storage array is reset on purpose: a cleared file is architecturally visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // A retiring write at the read address both forwards its data and clears its hazard now;
  // a same-cycle issue only shows up in rbusy from the next cycle.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic [PEND_W-1:0] pend_left;

    assign ra        = bus.raddr[k*ADDR_W +: ADDR_W];
    assign is_zero   = (ZERO_REG != 0) && (ra == '0);
    assign pend_left = pend[ra] - PEND_W'(dec_ok && (bus.waddr == ra));

    assign rd_val[k]  = is_zero                        ? '0        :
                        (wr_en && (bus.waddr == ra))   ? bus.wdata :
                                                         regs_q[ra];
    assign rd_busy[k] = !is_zero && (pend_left != '0);
  end

  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rdata[k*DATA_W +: DATA_W] = rd_val[k];
      bus.rbusy[k]                  = rd_busy[k];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, zero register, saturation,
// same-cycle issue/retire, four read ports and retire with nothing outstanding.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) bus ();

  regfile_scoreboard #(
    .DATA_W   (DW),
    .NUM_REGS (32),
    .NUM_RD   (NRD),
    .PEND_W   (2),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.we          = 1'b0;
    bus.waddr       = '0;
    bus.wdata       = '0;
    bus.retire      = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    bus.raddr = {reg_idx_t'(a3), reg_idx_t'(a2), reg_idx_t'(a1), reg_idx_t'(a0)};
  endtask

  task automatic issue(input int dest);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = reg_idx_t'(dest);
  endtask

  task automatic write(input int addr, input logic [31:0] data, input logic ret);
    bus.we     = 1'b1;
    bus.waddr  = reg_idx_t'(addr);
    bus.wdata  = data;
    bus.retire = ret;
  endtask

  // Advance one clock; inputs are then driven just after the falling edge.
  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rd(input int k);
    return bus.rdata[k*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    idle();
    set_rd(1, 2, 3, 5);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NRD; k++) check($sformatf("rst_rdata%0d", k), rd(k), 32'h0);
    check("rst_rbusy", 32'(bus.rbusy), 32'h0);
    check("rst_any_pending", 32'(bus.any_pending), 32'h0);
    check("rst_issue_stall", 32'(bus.issue_stall), 32'h0);
    reset = 1'b1;

    // Write-through bypass, then registered read-back.
    next();
    write(5, 32'hDEADBEEF, 1'b0);
    set_rd(5, 2, 0, 0);
    #1;
    check("byp_rdata0", rd(0), 32'hDEADBEEF);
    check("byp_other_port", rd(1), 32'h0);
    next();
    idle();
    #1;
    check("wr_readback", rd(0), 32'hDEADBEEF);

    // Register 0 ignores writes and issues.
    next();
    write(0, 32'h1234, 1'b0);
    issue(0);
    set_rd(0, 5, 0, 0);
    #1;
    check("zero_no_bypass", rd(0), 32'h0);
    check("zero_issue_stall", 32'(bus.issue_stall), 32'h0);
    check("zero_port1_intact", rd(1), 32'hDEADBEEF);
    next();
    idle();
    #1;
    check("zero_rdata", rd(0), 32'h0);
    check("zero_rbusy", 32'(bus.rbusy[0]), 32'h0);
    check("zero_any_pending", 32'(bus.any_pending), 32'h0);

    // Saturate register 7: three issues accepted, fourth stalls.
    set_rd(7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      next();
      idle();
      issue(7);
      #1;
      check($sformatf("sat_issue%0d_stall", i), 32'(bus.issue_stall), 32'h0);
      check($sformatf("sat_issue%0d_rbusy", i), 32'(bus.rbusy[0]), 32'(i != 0));
    end
    next();
    issue(7);
    #1;
    check("sat_fourth_stall", 32'(bus.issue_stall), 32'h1);
    check("sat_rbusy", 32'(bus.rbusy[0]), 32'h1);
    check("sat_any_pending", 32'(bus.any_pending), 32'h1);
    next();
    idle();
    write(7, 32'h77, 1'b1);
    #1;
    check("sat_retire_rbusy", 32'(bus.rbusy[0]), 32'h1);
    check("sat_retire_bypass", rd(0), 32'h77);
    check("sat_stall_no_valid", 32'(bus.issue_stall), 32'h0);
    next();
    idle();
    issue(7);
    #1;
    check("sat_after_retire_stall", 32'(bus.issue_stall), 32'h0);
    next();
    issue(7);
    #1;
    check("sat_refilled_stall", 32'(bus.issue_stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      next();
      idle();
      write(7, 32'h70 + 32'(i), 1'b1);
      #1;
      check($sformatf("drain%0d_rbusy", i), 32'(bus.rbusy[0]), 32'(i != 2));
    end
    next();
    idle();
    #1;
    check("drain_any_pending", 32'(bus.any_pending), 32'h0);
    check("drain_readback", rd(0), 32'h72);

    // Issue and retire to register 3 in the same cycle: count stays at 1.
    set_rd(3, 0, 0, 0);
    next();
    issue(3);
    next();
    idle();
    issue(3);
    write(3, 32'hABCD0003, 1'b1);
    #1;
    check("simul_rbusy", 32'(bus.rbusy[0]), 32'h0);
    check("simul_bypass", rd(0), 32'hABCD0003);
    check("simul_stall", 32'(bus.issue_stall), 32'h0);
    next();
    idle();
    #1;
    check("simul_pend_kept", 32'(bus.rbusy[0]), 32'h1);
    check("simul_any_pending", 32'(bus.any_pending), 32'h1);
    next();
    write(3, 32'h33, 1'b1);
    #1;
    check("simul_drain_rbusy", 32'(bus.rbusy[0]), 32'h0);
    next();
    idle();
    #1;
    check("simul_drain_any", 32'(bus.any_pending), 32'h0);

    // Four read ports, one address read on two ports.
    next();
    write(1, 32'h11, 1'b0);
    next();
    write(2, 32'h22, 1'b0);
    next();
    idle();
    set_rd(1, 2, 3, 1);
    #1;
    check("mp_rdata0", rd(0), 32'h11);
    check("mp_rdata1", rd(1), 32'h22);
    check("mp_rdata2", rd(2), 32'h33);
    check("mp_rdata3", rd(3), 32'h11);

    // Retire with nothing outstanding must not wrap the counter.
    next();
    write(2, 32'h22, 1'b1);
    #1;
    check("uflow_rbusy", 32'(bus.rbusy), 32'h0);
    next();
    idle();
    #1;
    check("uflow_any_pending", 32'(bus.any_pending), 32'h0);
    next();
    issue(2);
    #1;
    check("uflow_issue_stall", 32'(bus.issue_stall), 32'h0);
    next();
    idle();
    #1;
    check("uflow_single_pend", 32'(bus.rbusy), 32'h2);

    // Asynchronous reset in mid-traffic discards data and tracking.
    next();
    issue(9);
    write(9, 32'h99, 1'b0);
    set_rd(1, 2, 3, 9);
    #2;
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NRD; k++) check($sformatf("mid_rst_rdata%0d", k), rd(k), 32'h0);
    check("mid_rst_rbusy", 32'(bus.rbusy), 32'h0);
    check("mid_rst_any", 32'(bus.any_pending), 32'h0);
    reset = 1'b1;
    next();
    #1;
    check("post_rst_rdata0", rd(0), 32'h0);
    check("post_rst_rdata3", rd(3), 32'h0);
    check("post_rst_any", 32'(bus.any_pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
